// File: rtl/log_arith_pkg.sv
// Shared log-domain helpers for the Mitchell multiplier/divider family:
// leading-one detection and the normalized operand record.
package log_arith_pkg;

  localparam int FRAC_W = 15;
  localparam int K_W    = 5;

  typedef struct packed {
    logic              sign;
    logic [K_W-1:0]    k;
    logic [FRAC_W-1:0] frac;
  } log_operand_t;

  // Index of the most significant set bit; a zero input reports 0.
  function automatic logic [K_W-1:0] get_k(input logic [15:0] v);
    logic [K_W-1:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) k = K_W'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/log_lod_norm16.sv
// Combinational leading-one detector and normalizer: unsigned magnitude in,
// characteristic k and the 15-bit fraction below the leading one out.
module log_lod_norm16
  import log_arith_pkg::*;
(
  input  logic [15:0]       mag_i,
  output logic [K_W-1:0]    k_o,
  output logic [FRAC_W-1:0] frac_o
);

  logic [15:0] shifted;

  always_comb begin
    k_o     = get_k(mag_i);
    shifted = mag_i << (4'd15 - k_o[3:0]);
    frac_o  = shifted[14:0];
  end

endmodule

// File: rtl/mitchell_log_divider_16_pipe.sv
// Three-stage approximate signed 16-bit divider in the Mitchell log domain:
// normalize, subtract logs with error compensation, antilog and apply sign.
module mitchell_log_divider_16_pipe
  import log_arith_pkg::*;
#(
  parameter int M_WIDTH  = 10,
  parameter int FRAC_OUT = 8
)
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_q,
  output logic        o_dz
);

  localparam logic [FRAC_W-1:0] REM_MASK =
    FRAC_W'((32'd1 << (FRAC_W - M_WIDTH)) - 32'd1);

  logic advance;

  // Stage 1 state
  logic         s1Valid_q;
  log_operand_t s1A_q, s1B_q, s1A_d, s1B_d;
  logic         s1Az_q, s1Bz_q;

  // Stage 2 state
  logic                      s2Valid_q;
  logic                      s2Sign_q, s2Dz_q, s2Az_q;
  logic signed [5:0]         s2E_q, s2E_d;
  logic        [M_WIDTH:0]   s2Mant_q, s2Mant_d;

  // Output stage state
  logic        outValid_q;
  logic [31:0] outQ_q, outQ_d;
  logic        outDz_q;

  logic [15:0]       absA, absB;
  logic [K_W-1:0]    kA, kB;
  logic [FRAC_W-1:0] fracA, fracB;

  // One global enable: the whole pipe moves only when the output slot frees up.
  assign advance = ~outValid_q | i_ready;
  assign o_ready = advance;
  assign o_valid = outValid_q;
  assign o_q     = outQ_q;
  assign o_dz    = outDz_q;

  always_comb begin
    absA = i_a[15] ? 16'(-i_a) : i_a;
    absB = i_b[15] ? 16'(-i_b) : i_b;
  end

  log_lod_norm16 u_lod_a (
    .mag_i  (absA),
    .k_o    (kA),
    .frac_o (fracA)
  );

  log_lod_norm16 u_lod_b (
    .mag_i  (absB),
    .k_o    (kB),
    .frac_o (fracB)
  );

  always_comb begin
    s1A_d = '{sign: i_a[15], k: kA, frac: fracA};
    s1B_d = '{sign: i_b[15], k: kB, frac: fracB};
  end

  logic [M_WIDTH-1:0]      faT, fbT;
  logic [FRAC_W-1:0]       remA, remB;
  logic                    comp;
  logic signed [M_WIDTH+1:0] diff;
  logic signed [5:0]       eRaw;

  // Mantissa difference with the rounding compensation for truncated bits;
  // a borrow or a carry renormalizes mantissa into [1,2) and moves e by one.
  always_comb begin
    faT  = s1A_q.frac[FRAC_W-1 -: M_WIDTH];
    fbT  = s1B_q.frac[FRAC_W-1 -: M_WIDTH];
    remA = s1A_q.frac & REM_MASK;
    remB = s1B_q.frac & REM_MASK;
    comp = (M_WIDTH < FRAC_W) && (s1A_q.k >= K_W'(3)) &&
           (s1B_q.k >= K_W'(3)) && (remA > remB);
    diff = $signed({2'b00, faT}) - $signed({2'b00, fbT}) +
           $signed({{(M_WIDTH + 1){1'b0}}, comp});
    eRaw = $signed({1'b0, s1A_q.k}) - $signed({1'b0, s1B_q.k});
    s2E_d    = eRaw;
    s2Mant_d = {1'b1, diff[M_WIDTH-1:0]};
    if (diff[M_WIDTH+1]) begin
      s2E_d    = eRaw - 6'sd1;
      s2Mant_d = diff[M_WIDTH:0];
    end else if (diff[M_WIDTH]) begin
      s2E_d    = eRaw + 6'sd1;
      s2Mant_d = {1'b1, {M_WIDTH{1'b0}}};
    end
  end

  logic [15:0] mant16;
  logic [31:0] mag;
  int          sh;

  // Antilog: place the 1.15 mantissa at weight 2^(e) in the Q.FRAC_OUT output.
  always_comb begin
    mant16 = 16'(s2Mant_q) << (FRAC_W - M_WIDTH);
    sh     = int'(s2E_q) + FRAC_OUT - FRAC_W;
    if (sh >= 0) mag = {16'd0, mant16} << sh;
    else         mag = {16'd0, mant16} >> (-sh);
    if (s2Dz_q)      outQ_d = s2Sign_q ? 32'h8000_0001 : 32'h7FFF_FFFF;
    else if (s2Az_q) outQ_d = 32'd0;
    else             outQ_d = s2Sign_q ? -mag : mag;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Az_q     <= 1'b0;
      s1Bz_q     <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Sign_q   <= 1'b0;
      s2Dz_q     <= 1'b0;
      s2Az_q     <= 1'b0;
      s2E_q      <= '0;
      s2Mant_q   <= '0;
      outValid_q <= 1'b0;
      outQ_q     <= '0;
      outDz_q    <= 1'b0;
    end else if (advance) begin
      s1Valid_q  <= i_valid;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Az_q     <= (i_a == 16'd0);
      s1Bz_q     <= (i_b == 16'd0);
      s2Valid_q  <= s1Valid_q;
      s2Sign_q   <= s1A_q.sign ^ s1B_q.sign;
      s2Dz_q     <= s1Bz_q;
      s2Az_q     <= s1Az_q;
      s2E_q      <= s2E_d;
      s2Mant_q   <= s2Mant_d;
      outValid_q <= s2Valid_q;
      outQ_q     <= outQ_d;
      outDz_q    <= s2Dz_q;
    end
  end

endmodule

// File: tb/tb_mitchell_log_divider_16_pipe.sv
// Scoreboard bench for the pipelined Mitchell divider: directed vectors,
// stall/hold behaviour, async reset mid-stream and random valid/ready traffic.
module tb_mitchell_log_divider_16_pipe;

  localparam int M_WIDTH  = 10;
  localparam int FRAC_OUT = 8;

  typedef struct packed {
    logic        dz;
    logic [31:0] q;
  } result_t;

  logic               clock = 1'b0;
  logic               rstN;
  logic               valid;
  logic               oReady;
  logic signed [15:0] a, b;
  logic               oValid;
  logic               iReady;
  logic [31:0]        q;
  logic               dz;

  result_t sb[$];
  result_t expR;
  int      checks = 0;
  int      errors = 0;
  logic    done;
  logic [31:0] heldQ;

  always #5 clock = ~clock;

  mitchell_log_divider_16_pipe #(.M_WIDTH(M_WIDTH), .FRAC_OUT(FRAC_OUT)) dut (
    .i_clk   (clock),
    .i_rst_n (rstN),
    .i_valid (valid),
    .o_ready (oReady),
    .i_a     (a),
    .i_b     (b),
    .o_valid (oValid),
    .i_ready (iReady),
    .o_q     (q),
    .o_dz    (dz)
  );

  // Golden model written directly from the log-domain division algorithm.
  function automatic result_t model(input logic signed [15:0] av, input logic signed [15:0] bv);
    result_t r;
    longint ua, ub, fA, fB, faT, fbT, remA, remB, d, mant, mag;
    int ka, kb, e, s;
    logic sgn;
    sgn  = av[15] ^ bv[15];
    ua   = (av < 0) ? -longint'(av) : longint'(av);
    ub   = (bv < 0) ? -longint'(bv) : longint'(bv);
    r.dz = 1'b0;
    r.q  = 32'd0;
    if (ub == 0) begin
      r.dz = 1'b1;
      r.q  = sgn ? 32'h8000_0001 : 32'h7FFF_FFFF;
      return r;
    end
    if (ua == 0) return r;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (ua >= (longint'(1) << i)) ka = i;
      if (ub >= (longint'(1) << i)) kb = i;
    end
    fA   = ((ua - (longint'(1) << ka)) << 15) >> ka;
    fB   = ((ub - (longint'(1) << kb)) << 15) >> kb;
    faT  = fA >> (15 - M_WIDTH);
    fbT  = fB >> (15 - M_WIDTH);
    remA = fA - (faT << (15 - M_WIDTH));
    remB = fB - (fbT << (15 - M_WIDTH));
    e    = ka - kb;
    d    = faT - fbT + ((ka >= 3 && kb >= 3 && remA > remB) ? 1 : 0);
    if (d < 0) begin
      e--;
      mant = (longint'(2) << M_WIDTH) + d;
    end else if (d == (longint'(1) << M_WIDTH)) begin
      e++;
      mant = longint'(1) << M_WIDTH;
    end else begin
      mant = (longint'(1) << M_WIDTH) + d;
    end
    s   = e + FRAC_OUT - M_WIDTH;
    mag = (s >= 0) ? (mant << s) : (mant >>> (-s));
    r.q = 32'(sgn ? -mag : mag);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Caller enters just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic signed [15:0] av, input logic signed [15:0] bv);
    logic accepted;
    accepted = 1'b0;
    a     = av;
    b     = bv;
    valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (oReady) begin
        accepted = 1'b1;
        @(posedge clock);
        #1;
      end
    end
    checkOutput("accept_timeout", 32'(accepted), 32'd1);
    valid = 1'b0;
  endtask

  task automatic waitValid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (oValid) break;
    end
    checkOutput("wait_valid", 32'(oValid), 32'd1);
  endtask

  task automatic runVector(input string tag, input logic signed [15:0] av, input logic signed [15:0] bv,
                           input logic [31:0] expQ, input logic expDz);
    applyStimulus(av, bv);
    waitValid();
    checkOutput({tag, "_q"}, q, expQ);
    checkOutput({tag, "_dz"}, 32'(dz), 32'(expDz));
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (sb.size() == 0) break;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: push on every accept, pop and compare on every output transfer.
  always @(negedge clock) begin
    if (rstN) begin
      if (oValid && iReady) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          expR = sb.pop_front();
          checkOutput("sb_q", q, expR.q);
          checkOutput("sb_dz", 32'(dz), 32'(expR.dz));
        end
      end
      if (valid && oReady) sb.push_back(model(a, b));
    end
  end

  initial begin
    logic signed [15:0] ra, rb;
    valid  = 1'b0;
    a      = '0;
    b      = '0;
    iReady = 1'b1;
    rstN   = 1'b0;
    done   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_valid", 32'(oValid), 32'd0);
    checkOutput("reset_q", q, 32'd0);
    checkOutput("reset_dz", 32'(dz), 32'd0);
    rstN = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("idle_ready", 32'(oReady), 32'd1);

    $display("[TB] latency and directed vectors");
    applyStimulus(16'sd100, 16'sd10);
    checkOutput("lat_edge1", 32'(oValid), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("lat_edge2", 32'(oValid), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("lat_edge3", 32'(oValid), 32'd1);
    checkOutput("div_100_10_q", q, 32'd2688);
    checkOutput("div_100_10_dz", 32'(dz), 32'd0);
    @(posedge clock);
    #1;
    runVector("div_m64_8", -16'sd64, 16'sd8, 32'hFFFF_F800, 1'b0);
    runVector("div_3_2", 16'sd3, 16'sd2, 32'd384, 1'b0);
    runVector("div_2_3", 16'sd2, 16'sd3, 32'd192, 1'b0);
    runVector("div_7_0", 16'sd7, 16'sd0, 32'h7FFF_FFFF, 1'b1);
    runVector("div_m7_0", -16'sd7, 16'sd0, 32'h8000_0001, 1'b1);
    runVector("div_0_5", 16'sd0, 16'sd5, 32'd0, 1'b0);
    runVector("div_0_0", 16'sd0, 16'sd0, 32'h7FFF_FFFF, 1'b1);
    runVector("div_min_m1", 16'sh8000, -16'sd1, 32'h0080_0000, 1'b0);

    $display("[TB] stall with four back-to-back operands");
    iReady = 1'b0;
    fork
      begin
        applyStimulus(16'sd1000, 16'sd3);
        applyStimulus(-16'sd500, 16'sd7);
        applyStimulus(16'sd32767, 16'sd1);
        applyStimulus(16'sh8000, -16'sd1);
      end
      begin
        waitValid();
        checkOutput("stall_ready_low", 32'(oReady), 32'd0);
        heldQ = q;
        repeat (5) begin
          @(negedge clock);
          checkOutput("stall_hold_q", q, heldQ);
          checkOutput("stall_hold_valid", 32'(oValid), 32'd1);
        end
        @(posedge clock);
        #1 iReady = 1'b1;
        #1 checkOutput("ready_follows", 32'(oReady), 32'd1);
      end
    join
    drain("stall_drain");

    $display("[TB] async reset with operands in flight");
    applyStimulus(16'sd50, 16'sd5);
    applyStimulus(-16'sd9, 16'sd3);
    applyStimulus(16'sd77, -16'sd4);
    checkOutput("pre_reset_valid", 32'(oValid), 32'd1);
    #2 rstN = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_reset_valid", 32'(oValid), 32'd0);
    checkOutput("async_reset_q", q, 32'd0);
    repeat (2) @(posedge clock);
    #1 rstN = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checkOutput("post_reset_idle", 32'(oValid), 32'd0);
    end
    @(posedge clock);
    #1;
    runVector("post_reset_first", 16'sd3, 16'sd2, 32'd384, 1'b0);

    $display("[TB] random valid/ready traffic");
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          ra = ($urandom_range(0, 15) == 0) ? 16'sd0 : 16'($urandom);
          rb = ($urandom_range(0, 15) == 0) ? 16'sd0 : 16'($urandom);
          if ($urandom_range(0, 31) == 0) ra = 16'sh8000;
          if ($urandom_range(0, 31) == 0) rb = 16'sh8000;
          applyStimulus(ra, rb);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1 iReady = ($urandom_range(0, 3) != 0);
        end
        iReady = 1'b1;
      end
    join
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
